scan_chain_multi: RTL and testbench

Parametrised multi-chain scan register, successor to the single 4-bit scan shift register. It holds WIDTH independent chains of DEPTH bits each. It supports functional shift, parallel capture, manual scan shift, and an autonomous DEPTH-cycle scan load/unload sequence with a start/done handshake. A shadow update register drives parallel outputs, so test patterns can be applied without rippling.

---
 rtl/scan_pkg.sv | 18 +
 rtl/scan_chain_slice.sv | 33 +++
 rtl/scan_chain_multi.sv | 103 ++++++++++
 tb/tb_scan_chain_multi.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared encodings for the multi-chain scan register: operating modes and
// the auto-shift sequencer states.
package scan_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_FUNC = 2'b01,
        MODE_CAPT = 2'b10,
        MODE_SCAN = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/scan_chain_slice.sv
// One DEPTH-bit scan chain: the serial input enters bit 0 and bit DEPTH-1 is the
// exit bit. The operation for each edge is selected by op.
module scan_chain_slice
    import scan_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_t            op,
    input  logic             data_in,
    input  logic             scan_in,
    input  logic [DEPTH-1:0] pdata_in,
    output logic [DEPTH-1:0] chain,
    output logic             exit_bit
);

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            case (op)
                MODE_FUNC: chain <= {chain[DEPTH-2:0], data_in};
                MODE_CAPT: chain <= pdata_in;
                MODE_SCAN: chain <= {chain[DEPTH-2:0], scan_in};
                default:   chain <= chain;
            endcase
        end
    end

    assign exit_bit = chain[DEPTH-1];

endmodule

// File: rtl/scan_chain_multi.sv
// WIDTH parallel scan chains with a shadow update register and an autonomous
// DEPTH-shift load/unload sequencer. Optional macro SCAN_PARITY_EN adds a registered scan_out parity.
module scan_chain_multi
    import scan_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [WIDTH-1:0]       scan_in,
    input  logic [WIDTH*DEPTH-1:0] pdata_in,
    input  logic                   start,
    input  logic                   update,
    output logic [WIDTH-1:0]       data_out,
    output logic [WIDTH-1:0]       scan_out,
    output logic [WIDTH*DEPTH-1:0] pdata_out,
    output logic                   busy,
    output logic                   done,
    output logic                   scan_parity
);

    localparam int CW = $clog2(DEPTH);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH*DEPTH-1:0] chains;
    logic [WIDTH-1:0]       exit_bits;
    mode_t                  op;

    // Handshake: start is level-sampled only in IDLE; busy covers the SHIFT
    // cycles; done pulses for one cycle when the sequence retires. The start
    // edge performs the first shift, so the counter-zero edge only retires.
    always_comb begin
        op = MODE_HOLD;
        case (state)
            IDLE:    op = start ? MODE_SCAN : mode_t'(mode);
            SHIFT:   if (cnt != '0) op = MODE_SCAN;
            default: op = MODE_HOLD;
        endcase
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_chain
        scan_chain_slice #(.DEPTH(DEPTH)) u_slice (
            .clk      (clk),
            .rst      (rst),
            .op       (op),
            .data_in  (data_in[c]),
            .scan_in  (scan_in[c]),
            .pdata_in (pdata_in[c*DEPTH +: DEPTH]),
            .chain    (chains[c*DEPTH +: DEPTH]),
            .exit_bit (exit_bits[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pdata_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= CW'(DEPTH - 1);
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Shadow sees the pre-edge chains, even when the chains change on this edge.
            if (update && state != SHIFT) pdata_out <= chains;
        end
    end

    assign scan_out = exit_bits;
    assign data_out = (state == IDLE && mode != MODE_SCAN) ? exit_bits : '0;

`ifdef SCAN_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) scan_parity <= 1'b0;
        else     scan_parity <= ^exit_bits;
    end
`else
    assign scan_parity = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_multi.sv
// Directed bench for scan_chain_multi at WIDTH=2, DEPTH=4; expected values are
// hand-computed for each vector.
module tb_scan_chain_multi;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       data_in;
    logic [WIDTH-1:0]       scan_in;
    logic [WIDTH*DEPTH-1:0] pdata_in;
    logic                   start;
    logic                   update;
    logic [WIDTH-1:0]       data_out;
    logic [WIDTH-1:0]       scan_out;
    logic [WIDTH*DEPTH-1:0] pdata_out;
    logic                   busy;
    logic                   done;
    logic                   scan_parity;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_par;

    scan_chain_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .data_in     (data_in),
        .scan_in     (scan_in),
        .pdata_in    (pdata_in),
        .start       (start),
        .update      (update),
        .data_out    (data_out),
        .scan_out    (scan_out),
        .pdata_out   (pdata_out),
        .busy        (busy),
        .done        (done),
        .scan_parity (scan_parity)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; data_in = '0; scan_in = '0;
        pdata_in = '0; start = 1'b0; update = 1'b0;
        step();
        rst = 1'b0;

        // Arbitrary activity, then reset for two cycles
        mode = 2'b10; pdata_in = 8'hFF; step();
        mode = 2'b00; update = 1'b1; step();
        update = 1'b0; start = 1'b1; step();
        start = 1'b0; rst = 1'b1; step(); step();
        rst = 1'b0;
        check("rst_pdata_out", 32'(pdata_out), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_scan_out", 32'(scan_out), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_parity", 32'(scan_parity), 32'h0);

        // Functional shift: 11,00,11,11 -> each chain 1011
        exp_q.push_back(2'b00); exp_q.push_back(2'b00);
        exp_q.push_back(2'b00); exp_q.push_back(2'b11);
        mode = 2'b01;
        data_in = 2'b11; step(); check("func_dout0", 32'(data_out), 32'(exp_q.pop_front()));
        data_in = 2'b00; step(); check("func_dout1", 32'(data_out), 32'(exp_q.pop_front()));
        data_in = 2'b11; step(); check("func_dout2", 32'(data_out), 32'(exp_q.pop_front()));
        data_in = 2'b11; step(); check("func_dout3", 32'(data_out), 32'(exp_q.pop_front()));
        mode = 2'b00; update = 1'b1; step();
        update = 1'b0;
        check("func_shadow", 32'(pdata_out), 32'hBB);
        mode = 2'b11; #1;
        check("scan_mode_dout", 32'(data_out), 32'h0);
        check("scan_mode_sout", 32'(scan_out), 32'h3);
        mode = 2'b00;

        // Capture A5 (chain1=1010, chain0=0101), then update
        pdata_in = 8'hA5; mode = 2'b10; step();
        mode = 2'b00;
        check("capt_scan_out", 32'(scan_out), 32'h2);
        check("capt_shadow_held", 32'(pdata_out), 32'hBB);
        update = 1'b1; step();
        update = 1'b0;
        check("capt_shadow", 32'(pdata_out), 32'hA5);
`ifdef SCAN_PARITY_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        check("parity_10", 32'(scan_parity), 32'(exp_par));

        // Update and capture on the same edge: shadow gets the old chains
        pdata_in = 8'h3C; mode = 2'b10; update = 1'b1; step();
        mode = 2'b00; update = 1'b0;
        check("upd_capt_shadow", 32'(pdata_out), 32'hA5);
        check("upd_capt_sout", 32'(scan_out), 32'h1);

        // Auto-shift; mode is set to functional shift and must be ignored
        mode = 2'b01; data_in = 2'b11;
        start = 1'b1; scan_in = 2'b10; step();
        start = 1'b0;
        check("auto_busy0", 32'(busy), 32'h1);
        check("auto_dout_busy", 32'(data_out), 32'h0);
        scan_in = 2'b01; step();
        check("auto_busy1", 32'(busy), 32'h1);
        start = 1'b1; scan_in = 2'b10; step();
        start = 1'b0;
        check("auto_busy2", 32'(busy), 32'h1);
        check("auto_done2", 32'(done), 32'h0);
        scan_in = 2'b01; step();
        check("auto_busy3", 32'(busy), 32'h1);
        check("auto_done3", 32'(done), 32'h0);
        scan_in = 2'b11; mode = 2'b00; step();
        check("auto_done_pulse", 32'(done), 32'h1);
        check("auto_busy_done", 32'(busy), 32'h0);
        check("auto_sout", 32'(scan_out), 32'h2);
        update = 1'b1; step();
        update = 1'b0;
        check("auto_shadow", 32'(pdata_out), 32'hA5);
        check("auto_done_clear", 32'(done), 32'h0);
        check("auto_no_restart", 32'(busy), 32'h0);

        // Reset at the second shift of a sequence
        start = 1'b1; scan_in = 2'b11; step();
        start = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_sout", 32'(scan_out), 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            step();
            check("midrst_no_done", 32'(done), 32'h0);
        end
        update = 1'b1; step();
        update = 1'b0;
        check("midrst_shadow", 32'(pdata_out), 32'h00);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
